// File: rtl/dpd_lms_adapt_pkg.sv
// Shared types, state encoding and tap helpers for the DPD LMS adaptation engine.
package dpd_lms_adapt_pkg;

  localparam int DPD_W       = 20;
  localparam int C0_INIT_DEF = 349500;

  typedef logic signed [DPD_W-1:0] dpd_smp_t;
  typedef logic signed [DPD_W:0]   dpd_err_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } lms_state_e;

  // Taps are ordered order-major: tap k has polynomial order k/mem and memory lag k%mem.
  function automatic int tap_order(input int k, input int mem);
    return k / mem;
  endfunction

endpackage

// File: rtl/dpd_lms_adapt_tap.sv
// One LMS tap: complex basis * conj(error) product, scaling and coefficient accumulator.
// DPD_LMS_SAT_EN selects a saturating accumulator instead of two's-complement wrap.
module dpd_lms_adapt_tap #(
  parameter int W       = 20,
  parameter int RST_VAL = 0
) (
  input  logic                clk,
  input  logic                reset_b,
  input  logic                upd_i,
  input  logic signed [W-1:0] basis_re_i,
  input  logic signed [W-1:0] basis_im_i,
  input  logic signed [W-1:0] err_re_i,
  input  logic signed [W-1:0] err_im_i,
  output logic signed [W-1:0] coef_re_o,
  output logic signed [W-1:0] coef_im_o
);

  localparam int MW = 2*W;
  localparam int PW = 2*W + 1;

  logic signed [MW-1:0] m_rr_s, m_ii_s, m_ri_s, m_ir_s;
  logic signed [PW-1:0] prod_re_s, prod_im_s;
  logic signed [W:0]    p_re_s, p_im_s;
  logic signed [W+1:0]  sum_re_s, sum_im_s;
  logic signed [W-1:0]  coef_re_d, coef_im_d;
  logic signed [W-1:0]  coef_re_q, coef_im_q;
  logic                 unused_s;

`ifdef DPD_LMS_SAT_EN
  function automatic logic signed [W-1:0] sat_w(input logic signed [W+1:0] s);
    logic signed [W-1:0] r;
    if ((s[W+1:W-1] == 3'b000) || (s[W+1:W-1] == 3'b111)) begin
      r = s[W-1:0];
    end else if (s[W+1]) begin
      r = {1'b1, {(W-1){1'b0}}};
    end else begin
      r = {1'b0, {(W-1){1'b1}}};
    end
    return r;
  endfunction
`endif

  always_comb begin
    m_rr_s    = MW'(basis_re_i) * MW'(err_re_i);
    m_ii_s    = MW'(basis_im_i) * MW'(err_im_i);
    m_ri_s    = MW'(basis_re_i) * MW'(err_im_i);
    m_ir_s    = MW'(basis_im_i) * MW'(err_re_i);
    prod_re_s = PW'(m_rr_s) - PW'(m_ii_s);
    prod_im_s = PW'(m_ri_s) + PW'(m_ir_s);
    // >>> (W-1) then keep W+1 bits is a plain bit slice of the product
    p_re_s    = prod_re_s[2*W-1:W-1];
    p_im_s    = prod_im_s[2*W-1:W-1];
    sum_re_s  = (W+2)'(coef_re_q) + (W+2)'(p_re_s);
    sum_im_s  = (W+2)'(coef_im_q) + (W+2)'(p_im_s);
    if (upd_i) begin
`ifdef DPD_LMS_SAT_EN
      coef_re_d = sat_w(sum_re_s);
      coef_im_d = sat_w(sum_im_s);
`else
      coef_re_d = sum_re_s[W-1:0];
      coef_im_d = sum_im_s[W-1:0];
`endif
    end else begin
      coef_re_d = coef_re_q;
      coef_im_d = coef_im_q;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      coef_re_q <= W'(RST_VAL);
      coef_im_q <= '0;
    end else begin
      coef_re_q <= coef_re_d;
      coef_im_q <= coef_im_d;
    end
  end

  assign coef_re_o = coef_re_q;
  assign coef_im_o = coef_im_q;
  assign unused_s  = ^{prod_re_s[PW-1], prod_re_s[W-2:0], prod_im_s[PW-1], prod_im_s[W-2:0],
                       sum_re_s[W+1:W], sum_im_s[W+1:W]};

endmodule

// File: rtl/dpd_lms_adapt.sv
// LMS adaptation engine: sequences multi-pass training bursts and adapts a MEM x ORD coefficient bank.
// Define DPD_LMS_SAT_EN for saturating coefficient accumulators (default: wrap-around).
module dpd_lms_adapt
  import dpd_lms_adapt_pkg::*;
#(
  parameter int W           = 20,
  parameter int MEM         = 3,
  parameter int ORD         = 5,
  parameter int DELAY       = 41,
  parameter int TRAIN_LEN   = 800,
  parameter int ADAPT_START = 150,
  parameter int ADAPT_STOP  = 700,
  parameter int MU_SHIFT    = 3,
  parameter int PASSES      = 1,
  parameter int GAP_LEN     = 64,
  parameter int C0_INIT     = C0_INIT_DEF
) (
  input  logic                   clk,
  input  logic                   reset_b,
  input  logic                   start,
  input  logic                   abort,
  input  logic [W-1:0]           train_i,
  input  logic [W-1:0]           train_q,
  input  logic [W-1:0]           dpd_i,
  input  logic [W-1:0]           dpd_q,
  input  logic [MEM*ORD*W-1:0]   basis_i,
  input  logic [MEM*ORD*W-1:0]   basis_q,
  output logic [MEM*ORD*W-1:0]   coef_i,
  output logic [MEM*ORD*W-1:0]   coef_q,
  output logic                   train_en,
  output logic                   sel_fb,
  output logic                   busy,
  output logic                   done,
  output logic [3:0]             pass_cnt
);

  localparam int N = MEM * ORD;
  localparam logic [15:0] TE_END    = 16'(TRAIN_LEN);
  localparam logic [15:0] SF_LO     = 16'(DELAY);
  localparam logic [15:0] SF_HI     = 16'(DELAY + TRAIN_LEN);
  localparam logic [15:0] UP_LO     = 16'(DELAY + ADAPT_START);
  localparam logic [15:0] UP_HI     = 16'(DELAY + ADAPT_STOP);
  localparam logic [15:0] RUN_LAST  = 16'(DELAY + TRAIN_LEN - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_LEN - 1);
  localparam logic [3:0]  PASS_LAST = 4'(PASSES - 1);

  lms_state_e         state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic               phase_q, phase_d;
  logic [3:0]         pass_q, pass_d;
  logic               start_q, start_edge_s, run_s, upd_s;
  logic               train_en_q, sel_fb_q, busy_q, done_q;

  logic signed [W-1:0] dly_re_q [DELAY];
  logic signed [W-1:0] dly_im_q [DELAY];
  logic signed [W-1:0] dpd_re_s, dpd_im_s;
  logic signed [W:0]   e_re_q, e_im_q;
  logic signed [W+1:0] ce_re_s, ce_im_s;
  logic signed [W-1:0] err_re_s, err_im_s;
  logic [N*W-1:0]      basis_re_q, basis_im_q;
  logic                unused_s;

  assign start_edge_s = start & ~start_q;
  assign run_s        = (state_q == ST_RUN);
  assign upd_s        = run_s && (cnt_q >= UP_LO) && (cnt_q <= UP_HI) && phase_q && !abort;

  // Sequencer next-state: burst/gap counting, phase toggle, pass counting and abort override.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    pass_d  = pass_q;
    case (state_q)
      ST_IDLE: begin
        if (start_edge_s) begin
          state_d = ST_RUN;
          cnt_d   = 16'd0;
          phase_d = 1'b0;
          pass_d  = 4'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_q == RUN_LAST) begin
          cnt_d   = 16'd0;
          phase_d = 1'b0;
          if (pass_q < PASS_LAST) begin
            state_d = ST_GAP;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          cnt_d   = cnt_q + 16'd1;
          phase_d = ~phase_q;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_RUN;
          cnt_d   = 16'd0;
          phase_d = 1'b0;
          pass_d  = pass_q + 4'd1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d = ST_IDLE;
      cnt_d   = 16'd0;
      phase_d = 1'b0;
      pass_d  = 4'd0;
    end else begin
      state_d = state_d;
    end
  end

  // Sequencer state and registered control outputs.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 16'd0;
      phase_q    <= 1'b0;
      pass_q     <= 4'd0;
      start_q    <= 1'b0;
      train_en_q <= 1'b0;
      sel_fb_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      pass_q     <= pass_d;
      start_q    <= start;
      train_en_q <= run_s && (cnt_q < TE_END) && !abort;
      sel_fb_q   <= run_s && (cnt_q >= SF_LO) && (cnt_q < SF_HI) && !abort;
      busy_q     <= (state_d != ST_IDLE);
      done_q     <= (state_d == ST_DONE);
    end
  end

  // Reference delay line matching the transceiver + PA loop.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      for (int i = 0; i < DELAY; i++) begin
        dly_re_q[i] <= '0;
        dly_im_q[i] <= '0;
      end
    end else begin
      dly_re_q[0] <= train_i;
      dly_im_q[0] <= train_q;
      for (int i = 1; i < DELAY; i++) begin
        dly_re_q[i] <= dly_re_q[i-1];
        dly_im_q[i] <= dly_im_q[i-1];
      end
    end
  end

  assign dpd_re_s = dpd_i;
  assign dpd_im_s = dpd_q;

  // Error register; basis is captured on phase 0 and consumed by the taps on phase 1.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      e_re_q     <= '0;
      e_im_q     <= '0;
      basis_re_q <= '0;
      basis_im_q <= '0;
    end else begin
      e_re_q <= (W+1)'(dly_re_q[DELAY-1]) - (W+1)'(dpd_re_s);
      e_im_q <= (W+1)'(dly_im_q[DELAY-1]) - (W+1)'(dpd_im_s);
      if (!phase_q) begin
        basis_re_q <= basis_i;
        basis_im_q <= basis_q;
      end else begin
        basis_re_q <= basis_re_q;
        basis_im_q <= basis_im_q;
      end
    end
  end

  assign ce_re_s  = (W+2)'(e_re_q) >>> MU_SHIFT;
  assign ce_im_s  = (-((W+2)'(e_im_q))) >>> MU_SHIFT;
  assign err_re_s = ce_re_s[W-1:0];
  assign err_im_s = ce_im_s[W-1:0];
  assign unused_s = ^{ce_re_s[W+1:W], ce_im_s[W+1:W]};

  for (genvar k = 0; k < N; k++) begin : g_tap
    dpd_lms_adapt_tap #(
      .W       (W),
      .RST_VAL ((tap_order(k, MEM) == 0) ? C0_INIT : 0)
    ) u_tap (
      .clk        (clk),
      .reset_b    (reset_b),
      .upd_i      (upd_s),
      .basis_re_i (basis_re_q[k*W +: W]),
      .basis_im_i (basis_im_q[k*W +: W]),
      .err_re_i   (err_re_s),
      .err_im_i   (err_im_s),
      .coef_re_o  (coef_i[k*W +: W]),
      .coef_im_o  (coef_q[k*W +: W])
    );
  end

  assign train_en = train_en_q;
  assign sel_fb   = sel_fb_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass_cnt = pass_q;

endmodule

// File: tb/tb_dpd_lms_adapt.sv
// Directed bench for dpd_lms_adapt: 3-pass sequencing, exact LMS increments, wrap/saturation, abort.
module tb_dpd_lms_adapt;

  localparam int W   = 20;
  localparam int MEM = 3;
  localparam int N   = 15;

`ifdef DPD_LMS_SAT_EN
  localparam longint CI0_FIN = 524287;
  localparam longint CI0_ABT = 524287;
`else
  localparam longint CI0_FIN = -487108;
  localparam longint CI0_ABT = -460228;
`endif

  logic           clk = 1'b0;
  logic           reset_b = 1'b0;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic [W-1:0]   train_i, train_q, dpd_i, dpd_q;
  logic [N*W-1:0] basis_i, basis_q, coef_i, coef_q;
  logic           train_en, sel_fb, busy, done;
  logic [3:0]     pass_cnt;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int t, bad_d, busy0;
  int te_r[$], te_f[$], sf_r[$], sf_f[$], dn[$], bf[$], pc_r[$], chg[$];
  logic p_te, p_sf, p_busy;
  logic [W-1:0] p_cq0;

  dpd_lms_adapt #(.PASSES(3), .GAP_LEN(64)) dut (
    .clk(clk), .reset_b(reset_b), .start(start), .abort(abort),
    .train_i(train_i), .train_q(train_q), .dpd_i(dpd_i), .dpd_q(dpd_q),
    .basis_i(basis_i), .basis_q(basis_q), .coef_i(coef_i), .coef_q(coef_q),
    .train_en(train_en), .sel_fb(sel_fb), .busy(busy), .done(done), .pass_cnt(pass_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint ci(input int k);
    logic signed [W-1:0] v;
    v = coef_i[k*W +: W];
    return longint'(v);
  endfunction

  function automatic longint cq(input int k);
    logic signed [W-1:0] v;
    v = coef_q[k*W +: W];
    return longint'(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic clear_log();
    te_r.delete(); te_f.delete(); sf_r.delete(); sf_f.delete();
    dn.delete(); bf.delete(); pc_r.delete(); chg.delete();
    bad_d = 0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    t = 0;
    busy0 = int'(busy);
    p_te = train_en; p_sf = sel_fb; p_busy = busy; p_cq0 = coef_q[W-1:0];
  endtask

  // Runs ncyc cycles logging output edges and every coef_q[0] step (expected step dq).
  task automatic mon(input int ncyc, input int dq);
    logic signed [W-1:0] dlt;
    for (int i = 0; i < ncyc; i++) begin
      tick();
      if (train_en && !p_te) begin te_r.push_back(t); pc_r.push_back(int'(pass_cnt)); end
      if (!train_en && p_te) te_f.push_back(t);
      if (sel_fb && !p_sf) sf_r.push_back(t);
      if (!sel_fb && p_sf) sf_f.push_back(t);
      if (done) dn.push_back(t);
      if (!busy && p_busy) bf.push_back(t);
      if (coef_q[W-1:0] != p_cq0) begin
        chg.push_back(t);
        dlt = coef_q[W-1:0] - p_cq0;
        if (int'(dlt) != dq) bad_d++;
      end
      p_te = train_en; p_sf = sel_fb; p_busy = busy; p_cq0 = coef_q[W-1:0];
    end
  endtask

  initial begin
    t = 0; bad_d = 0; busy0 = 0;
    train_i = 20'd1000; train_q = 20'd0; dpd_i = 20'd1000; dpd_q = 20'd0;
    basis_i = '0; basis_q = '0;
    basis_i[0*W +: W] = 20'd262144;
    basis_q[1*W +: W] = 20'd262144;
    repeat (3) @(posedge clk);
    #1 reset_b = 1'b1;
    repeat (100) tick();

    // Reset / idle state
    for (int k = 0; k < N; k++) begin
      chk("rst_coef_i", ci(k), (k < MEM) ? 64'sd349500 : 64'sd0);
      chk("rst_coef_q", cq(k), 64'sd0);
    end
    chk("rst_busy", busy, 0);
    chk("rst_train_en", train_en, 0);
    chk("rst_sel_fb", sel_fb, 0);
    chk("rst_done", done, 0);
    chk("rst_pass_cnt", pass_cnt, 0);

    // Three passes with zero error: sequencing only
    clear_log();
    do_start();
    chk("busy_after_start", busy0, 1);
    mon(2700, 0);
    chk("te_bursts", te_r.size(), 3);
    chk("te_falls", te_f.size(), 3);
    chk("sf_rises", sf_r.size(), 3);
    chk("sf_falls", sf_f.size(), 3);
    if (te_r.size() == 3 && te_f.size() == 3 && sf_r.size() == 3 && sf_f.size() == 3) begin
      for (int p = 0; p < 3; p++) begin
        chk("te_rise_t", te_r[p], 1 + 905*p);
        chk("te_len", te_f[p] - te_r[p], 800);
        chk("sf_delay", sf_r[p] - te_r[p], 41);
        chk("sf_len", sf_f[p] - sf_r[p], 800);
        chk("pass_cnt_at_burst", pc_r[p], p);
      end
      chk("gap_low_1", te_r[1] - te_f[0], 105);
      chk("gap_low_2", te_r[2] - te_f[1], 105);
    end
    chk("done_pulses", dn.size(), 1);
    if (dn.size() == 1) chk("done_t", dn[0], 2651);
    chk("busy_falls", bf.size(), 1);
    if (bf.size() == 1) chk("busy_fall_t", bf[0], 2652);
    chk("zero_err_steps", chg.size(), 0);
    for (int k = 0; k < N; k++) begin
      chk("zero_err_coef_i", ci(k), (k < MEM) ? 64'sd349500 : 64'sd0);
      chk("zero_err_coef_q", cq(k), 64'sd0);
    end

    // Constant error e = 4096 - j2048: exact per-update steps and pass totals
    train_i = 20'd4096; train_q = 20'd0; dpd_i = 20'd0; dpd_q = 20'd2048;
    repeat (60) tick();
    clear_log();
    do_start();
    mon(800, 128);
    chk("p1_steps", chg.size(), 276);
    if (chg.size() == 276) begin
      chk("p1_first_step_t", chg[0], 192);
      chk("p1_last_step_t", chg[275], 742);
    end
    chk("p1_ci0", ci(0), 420156);
    chk("p1_cq0", cq(0), 35328);
    chk("p1_ci1", ci(1), 314172);
    chk("p1_cq1", cq(1), 70656);
    mon(1900, 128);
    chk("all_steps", chg.size(), 828);
    if (chg.size() == 828) chk("p3_last_step_t", chg[827], 2552);
    chk("bad_step_size", bad_d, 0);
    chk("fin_ci0_wrap_or_sat", ci(0), CI0_FIN);
    chk("fin_cq0", cq(0), 105984);
    chk("fin_ci1", ci(1), 243516);
    chk("fin_cq1", cq(1), 211968);
    chk("fin_ci2", ci(2), 349500);
    chk("fin_ci3", ci(3), 0);
    chk("fin_cq14", cq(14), 0);
    chk("adapt_done_pulses", dn.size(), 1);

    // Abort at cnt = 400
    clear_log();
    do_start();
    mon(400, 128);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_pass_cnt", pass_cnt, 0);
    chk("abort_cq0", cq(0), 119424);
    chk("abort_ci0", ci(0), CI0_ABT);
    chk("abort_ci1", ci(1), 230076);
    chk("abort_cq1", cq(1), 238848);
    mon(50, 128);
    chk("abort_steps", chg.size(), 105);
    chk("abort_no_done", dn.size(), 0);
    chk("abort_frozen_cq0", cq(0), 119424);
    chk("abort_idle_busy", busy, 0);

    // Start edge coincident with abort is ignored
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    tick();
    chk("start_abort_busy", busy, 0);
    tick();
    chk("start_abort_train_en", train_en, 0);

    // Restart after abort begins again at cnt = 0
    clear_log();
    do_start();
    chk("restart_busy", busy0, 1);
    mon(200, 128);
    chk("restart_bursts", te_r.size(), 1);
    if (te_r.size() == 1) chk("restart_te_rise", te_r[0], 1);
    chk("restart_steps", chg.size(), 5);
    if (chg.size() == 5) chk("restart_first_step", chg[0], 192);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("final_abort_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
